// File: rtl/wallace_acc_pkg.sv
// Shared types and constants for the Wallace-tree product accumulator.
package wallace_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 8x8 multiplier tree yields a 16-bit product
    localparam int PROD_W_DEF  = 16;
    localparam int N_TERMS_DEF = 8;
    // PROD_W + clog2(N_TERMS): wide enough that a full frame never wraps
    localparam int ACC_W_DEF   = 19;

    // Counter must be able to hold the value N_TERMS itself
    function automatic int cnt_width(input int n_terms);
        return (n_terms < 1) ? 1 : $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/acc_adder_reg.sv
// Registered accumulator adder: acc <= acc + addend when enabled, with the
// carry out of the top bit exposed combinationally for overflow tracking.
module acc_adder_reg #(
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] acc,
    output logic             carry_out
);

    logic [ACC_W:0] sum;

    // One-bit-wider sum so the carry out of the accumulator is visible
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, addend};
        carry_out = sum[ACC_W];
    end

    // Accumulator register; clear wins over enable, sum wraps modulo 2^ACC_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/wallace_product_accumulator.sv
// Accumulates N_TERMS products from the approximate Wallace-tree multiplier
// into a wide sum. One registered product stage sits ahead of the adder, and
// the finished sum is presented on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting products, up to N_TERMS
// DRAIN | all products accepted, final addition in flight
// DONE  | sum valid on acc_out, waiting for out_ready
module wallace_product_accumulator
    import wallace_acc_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = cnt_width(N_TERMS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    // Count value at which the current accept/add is the frame's last one
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t            state;
    logic [PROD_W-1:0] p_reg;
    logic              p_vld;
    logic [CNT_W-1:0]  accept_cnt;
    logic [CNT_W-1:0]  add_cnt;

    logic              accept;
    logic              start_frame;
    logic              clr_acc;
    logic [ACC_W-1:0]  addend;
    logic              add_carry;

    // Handshake qualifiers; a start is honoured in IDLE, or in DONE together
    // with the output handshake so frames can run back-to-back
    always_comb begin
        accept      = in_valid & in_ready;
        start_frame = start & ((state == IDLE) |
                               ((state == DONE) & out_valid & out_ready));
        clr_acc     = clear | start_frame;
        addend      = ACC_W'(p_reg);
    end

    acc_adder_reg #(
        .ACC_W (ACC_W)
    ) u_adder (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_acc),
        .en        (p_vld),
        .addend    (addend),
        .acc       (acc_out),
        .carry_out (add_carry)
    );

    // Frame sequencing, product register, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p_reg      <= '0;
            p_vld      <= 1'b0;
            accept_cnt <= '0;
            add_cnt    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            // Abort: any product still in p_reg is dropped
            state      <= IDLE;
            p_vld      <= 1'b0;
            accept_cnt <= '0;
            add_cnt    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            p_vld <= 1'b0;
            if (p_vld) begin
                add_cnt <= add_cnt + 1'b1;
                if (add_carry) begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        accept_cnt <= '0;
                        add_cnt    <= '0;
                        overflow   <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        p_reg      <= prod_in;
                        p_vld      <= 1'b1;
                        accept_cnt <= accept_cnt + 1'b1;
                        if (accept_cnt == LAST_CNT) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Last product is added on this edge; sum is final after it
                    if (p_vld && (add_cnt == LAST_CNT)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state      <= ACCUM;
                            accept_cnt <= '0;
                            add_cnt    <= '0;
                            overflow   <= 1'b0;
                            in_ready   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Directed bench for wallace_product_accumulator. Instance a uses the default
// configuration (N_TERMS=8, ACC_W=19); instance b is a narrow N_TERMS=2,
// ACC_W=16 build to exercise overflow. Expected sums come from a bench model
// and go through a scoreboard queue.
module tb_wallace_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] prod_in;

    logic        in_ready_a, out_valid_a, overflow_a, busy_a;
    logic [18:0] acc_a;
    logic        in_ready_b, out_valid_b, overflow_b, busy_b;
    logic [15:0] acc_b;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wallace_product_accumulator u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .clear     (clear),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .acc_out   (acc_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .overflow  (overflow_a),
        .busy      (busy_a)
    );

    wallace_product_accumulator #(
        .N_TERMS (2),
        .ACC_W   (16)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .clear     (clear),
        .prod_in   (prod_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .acc_out   (acc_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .overflow  (overflow_b),
        .busy      (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: running sum modulo 2^accw, sticky carry-out flag
    function automatic exp_t model(input logic [15:0] p[$], input int accw);
        exp_t        e;
        logic [32:0] s;
        logic [32:0] lim;
        s     = '0;
        lim   = 33'd1 << accw;
        e.ovf = 1'b0;
        foreach (p[i]) begin
            s = s + 33'(p[i]);
            if (s >= lim) begin
                e.ovf = 1'b1;
                s     = s - lim;
            end
        end
        e.acc = s[31:0];
        return e;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? in_ready_b : in_ready_a;
    endfunction

    function automatic logic ovld(input bit sel);
        return sel ? out_valid_b : out_valid_a;
    endfunction

    function automatic logic [31:0] accv(input bit sel);
        return sel ? 32'(acc_b) : 32'(acc_a);
    endfunction

    function automatic logic ovfv(input bit sel);
        return sel ? overflow_b : overflow_a;
    endfunction

    task automatic do_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Present one product and hold it until it is taken
    task automatic send(input bit sel, input logic [15:0] p);
        int guard = 0;
        prod_in  = p;
        in_valid = 1'b1;
        while (!rdy(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("send_in_ready", 32'(rdy(sel)), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bit sel, input logic [15:0] prods[$],
                             input bit stall, input bit with_start);
        sb.push_back(model(prods, sel ? 16 : 19));
        if (with_start) do_start(sel);
        foreach (prods[i]) begin
            send(sel, prods[i]);
            if (stall && i != prods.size() - 1) @(negedge clk);
        end
    endtask

    task automatic wait_out(input bit sel, output int lat);
        lat = 0;
        while (!ovld(sel) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_out(input bit sel, input string tag);
        exp_t e;
        check({tag, "_valid"}, 32'(ovld(sel)), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_acc"}, accv(sel), e.acc);
            check({tag, "_ovf"}, 32'(ovfv(sel)), 32'(e.ovf));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] q[$];
        exp_t        e;
        int          lat;
        logic        seen;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; clear = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; prod_in = '0;

        // Reset state
        @(negedge clk);
        check("rst_acc", accv(0), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready_a), 32'd0);

        // Basic frame 1..8 back-to-back
        q = {};
        for (int i = 1; i <= 8; i++) q.push_back(16'(i));
        run_frame(0, q, 0, 1);
        check("basic_no_early_valid", 32'(out_valid_a), 32'd0);
        wait_out(0, lat);
        check("basic_latency", 32'(lat), 32'd1);
        check_out(0, "basic");
        handshake();
        check("basic_idle_busy", 32'(busy_a), 32'd0);

        // Maximum products
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(16'hFE01);
        run_frame(0, q, 0, 1);
        wait_out(0, lat);
        check("max_acc_const", accv(0), 32'h7F008);
        check_out(0, "max");
        handshake();

        // Stalled input, then backpressure on the output
        q = {};
        for (int i = 1; i <= 8; i++) q.push_back(16'(100 * i));
        run_frame(0, q, 1, 1);
        wait_out(0, lat);
        check("stall_acc_const", accv(0), 32'd3600);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(out_valid_a), 32'd1);
            check("bp_acc_stable", accv(0), e.acc);
            @(negedge clk);
        end
        out_ready = 1'b1;
        start_a   = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start_a   = 1'b0;
        check("b2b_busy", 32'(busy_a), 32'd1);
        check("b2b_acc_zero", accv(0), 32'd0);
        check("b2b_out_valid", 32'(out_valid_a), 32'd0);
        check("b2b_in_ready", 32'(in_ready_a), 32'd1);
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(16'd5);
        run_frame(0, q, 0, 0);
        wait_out(0, lat);
        check_out(0, "b2b");
        handshake();

        // Start during DRAIN must be ignored
        q = {};
        for (int i = 1; i <= 8; i++) q.push_back(16'(10 * i));
        run_frame(0, q, 0, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_out(0, lat);
        check("drain_start_latency", 32'(lat), 32'd0);
        check_out(0, "drain_start");
        handshake();
        check("drain_start_idle", 32'(busy_a), 32'd0);

        // Clear coincident with the 8th accept
        do_start(0);
        for (int i = 1; i <= 7; i++) send(0, 16'(i));
        check("clr_in_ready_before", 32'(in_ready_a), 32'd1);
        prod_in  = 16'd8;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        check("clr_busy", 32'(busy_a), 32'd0);
        check("clr_acc", accv(0), 32'd0);
        check("clr_in_ready", 32'(in_ready_a), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | out_valid_a;
            @(negedge clk);
        end
        check("clr_no_out_valid", 32'(seen), 32'd0);

        // Asynchronous reset mid-frame
        do_start(0);
        send(0, 16'd5);
        send(0, 16'd6);
        send(0, 16'd7);
        check("midrst_busy_before", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_acc", accv(0), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a), 32'd0);
        check("midrst_out_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_post_in_ready", 32'(in_ready_a), 32'd0);
        check("midrst_post_busy", 32'(busy_a), 32'd0);

        // Overflow on the narrow instance
        q = {};
        q.push_back(16'hFFFF);
        q.push_back(16'h0002);
        run_frame(1, q, 0, 1);
        wait_out(1, lat);
        check("ovf_latency", 32'(lat), 32'd1);
        check("ovf_acc_const", accv(1), 32'h0001);
        check_out(1, "ovf");
        handshake();
        check("ovf_held_idle", 32'(overflow_b), 32'd1);
        do_start(1);
        check("ovf_cleared_by_start", 32'(overflow_b), 32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("ovf_b_idle", 32'(busy_b), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
